par_serial_tx: RTL and testbench

Parallel-to-serial transmitter stage directly downstream of the lane muxes (the 2:1 mux stage on clk_2f).
- Takes the mux output byte and its valid, and serializes it MSB-first on a bit clock running 8x the byte rate.
- After reset, it transmits a programmable number of COM symbols, then sends data bytes.
- Sends an IDLE symbol in any byte slot whose valid is low.
- It is the last digital stage before the serial link.

---
 rtl/par_serial_tx.sv | 63 ++++++
 tb/tb_par_serial_tx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/par_serial_tx.sv
// Parallel-to-serial transmitter: frames a COM preamble after reset, then shifts
// out data bytes (or IDLE when unqualified) MSB-first on the 8x bit clock.
module par_serial_tx #(
    parameter logic [7:0] COM_SYM    = 8'hBC,
    parameter logic [7:0] IDLE_SYM   = 8'h7C,
    parameter int         SYNC_BYTES = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       data_out,
    output logic       load_strobe,
    output logic       sync_done
);

    localparam logic [0:0] ST_SYNC   = 1'b0;
    localparam logic [0:0] ST_DATA   = 1'b1;
    localparam logic [7:0] SYNC_LAST = 8'(SYNC_BYTES - 1);

    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [0:0] state;
    logic [7:0] sync_cnt;
    logic [7:0] next_byte;

    assign load_strobe = (bit_cnt == 3'd7);
    assign data_out    = shreg[7];
    assign sync_done   = (state == ST_DATA);

    // Inputs are only looked at during SYNC-exit-free DATA load slots
    always_comb begin
        next_byte = COM_SYM;
        if (state == ST_DATA) begin
            next_byte = valid_in ? data_in : IDLE_SYM;
        end
    end

    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            bit_cnt  <= 3'd7;
            shreg    <= 8'h00;
            state    <= ST_SYNC;
            sync_cnt <= 8'd0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if (load_strobe) begin
                shreg <= next_byte;
            end else begin
                shreg <= {shreg[6:0], 1'b0};
            end
            // The edge that ends SYNC still loads COM; data starts one byte later
            if (load_strobe && state == ST_SYNC) begin
                if (sync_cnt == SYNC_LAST) begin
                    state <= ST_DATA;
                end else begin
                    sync_cnt <= sync_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_par_serial_tx.sv
// Directed bench for par_serial_tx: sync preamble, data/idle slots, async reset,
// and a single-COM configuration running alongside.
module tb_par_serial_tx;

    logic       clk_8f;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       data_out, load_strobe, sync_done;
    logic       data_out1, load_strobe1, sync_done1;

    int total = 0;
    int bad   = 0;

    logic [63:0] s0, s1;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[7];

    par_serial_tx dut (
        .clk_8f(clk_8f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .data_out(data_out), .load_strobe(load_strobe), .sync_done(sync_done)
    );

    par_serial_tx #(.SYNC_BYTES(1)) dut1 (
        .clk_8f(clk_8f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .data_out(data_out1), .load_strobe(load_strobe1), .sync_done(sync_done1)
    );

    initial begin
        clk_8f = 1'b0;
        forever #5 clk_8f = ~clk_8f;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_8f);
        #1;
    endtask

    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            s0 = {s0[62:0], data_out};
            s1 = {s1[62:0], data_out1};
        end
    endtask

    // Drives one load slot, then scrambles the inputs on every non-load edge
    task automatic send_byte(input logic v, input logic [7:0] d, output logic [7:0] got);
        check("strobe_at_load", {31'd0, load_strobe}, 32'd1);
        valid_in = v;
        data_in  = d;
        got = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick();
            got = {got[6:0], data_out};
            data_in  = i[0] ? 8'h00 : 8'hFF;
            valid_in = i[0];
        end
    endtask

    initial begin
        logic [7:0] got;

        vecs[0] = '{1'b1, 8'hA5, 8'hA5, "data_a5"};
        vecs[1] = '{1'b1, 8'h3C, 8'h3C, "data_3c"};
        vecs[2] = '{1'b0, 8'hA5, 8'h7C, "idle_a"};
        vecs[3] = '{1'b1, 8'h81, 8'h81, "data_81"};
        vecs[4] = '{1'b0, 8'hFF, 8'h7C, "idle_b"};
        vecs[5] = '{1'b1, 8'h00, 8'h00, "data_00"};
        vecs[6] = '{1'b1, 8'h7C, 8'h7C, "data_7c"};

        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        s0 = '0;
        s1 = '0;
        repeat (2) tick();
        check("rst_data_out", {31'd0, data_out}, 32'd0);
        check("rst_load_strobe", {31'd0, load_strobe}, 32'd1);
        check("rst_sync_done", {31'd0, sync_done}, 32'd0);
        reset = 1'b0;

        // Preamble with default and single-COM configurations side by side
        collect(1);
        check("sb1_sync_done_e1", {31'd0, sync_done1}, 32'd1);
        check("sync_done_e1", {31'd0, sync_done}, 32'd0);
        collect(7);
        check("sb1_strobe_e9", {31'd0, load_strobe1}, 32'd1);
        valid_in = 1'b1;
        data_in  = 8'h5A;
        collect(1);
        valid_in = 1'b0;
        data_in  = 8'h00;
        collect(15);
        check("sync_done_e24", {31'd0, sync_done}, 32'd0);
        collect(1);
        check("sync_done_e25", {31'd0, sync_done}, 32'd1);
        collect(7);
        check("com_x4", s0[31:0], 32'hBCBCBCBC);
        check("sb1_com", {24'd0, s1[31:24]}, 32'hBC);
        check("sb1_first_data", {24'd0, s1[23:16]}, 32'h5A);
        check("sb1_idle", {24'd0, s1[15:8]}, 32'h7C);
        check("strobe_e33", {31'd0, load_strobe}, 32'd1);
        collect(8);
        check("first_idle", {24'd0, s0[7:0]}, 32'h7C);

        // Back-to-back data/idle slots with inputs scrambled between loads
        for (int i = 0; i < 7; i++) begin
            send_byte(vecs[i].v, vecs[i].d, got);
            check(vecs[i].name, {24'd0, got}, {24'd0, vecs[i].exp});
        end

        // Async reset three bits into an all-ones byte
        valid_in = 1'b1;
        data_in  = 8'hFF;
        check("strobe_pre_rst", {31'd0, load_strobe}, 32'd1);
        repeat (3) tick();
        check("mid_byte_bit", {31'd0, data_out}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_data_out", {31'd0, data_out}, 32'd0);
        check("async_sync_done", {31'd0, sync_done}, 32'd0);
        check("async_strobe", {31'd0, load_strobe}, 32'd1);
        tick();
        reset = 1'b0;

        // Valid FF held through the whole resync
        s0 = '0;
        collect(24);
        check("resync_sd_e24", {31'd0, sync_done}, 32'd0);
        collect(1);
        check("resync_sd_e25", {31'd0, sync_done}, 32'd1);
        collect(15);
        check("resync_com_x4", s0[39:8], 32'hBCBCBCBC);
        check("resync_first_ff", {24'd0, s0[7:0]}, 32'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
